// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: synchronises the divided step clock, mode and pause switches into clk_in
// and advances one of four LED patterns (chase, bounce, fill, blink) per detected step_clk rising edge.
module led_pattern_seq #(
  parameter int N_LEDS = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              step_clk,
  input  logic [1:0]        mode,
  input  logic              pause,
  output logic [N_LEDS-1:0] led_out,
  output logic              step_tick
);

  localparam int CW = $clog2(N_LEDS + 1);

  typedef enum logic [1:0] {
    CHASE  = 2'b00,
    BOUNCE = 2'b01,
    FILL   = 2'b10,
    BLINK  = 2'b11
  } pat_e;

  function automatic logic [N_LEDS-1:0] init_pat(input pat_e p);
    logic [N_LEDS-1:0] v;
    v = N_LEDS'(1);
    if (p == BLINK) begin
      for (int i = 0; i < N_LEDS; i++) v[i] = ((i % 2) == 0);
    end
    return v;
  endfunction

  // Computed one bit wider so cnt == N_LEDS yields all ones without overflow.
  function automatic logic [N_LEDS-1:0] fill_val(input logic [CW-1:0] cnt);
    logic [N_LEDS:0] w;
    w = {{N_LEDS{1'b0}}, 1'b1} << cnt;
    w = w - {{N_LEDS{1'b0}}, 1'b1};
    return w[N_LEDS-1:0];
  endfunction

  logic              s1_q, s2_q, s3_q, s1_d, s2_d, s3_d;
  logic [1:0]        m1_q, m2_q, m1_d, m2_d;
  logic              p1_q, p2_q, p1_d, p2_d;
  pat_e              mode_q, mode_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic              dir_left_q, dir_left_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic              step, reload;

  always_comb begin
    s1_d = step_clk;
    s2_d = s1_q;
    s3_d = s2_q;
    m1_d = mode;
    m2_d = m1_q;
    p1_d = pause;
    p2_d = p1_q;
  end

  always_comb begin
    mode_d     = mode_q;
    led_d      = led_q;
    dir_left_d = dir_left_q;
    cnt_d      = cnt_q;
    tick_d     = 1'b0;
    step       = s2_q & ~s3_q;
    reload     = (m2_q != mode_q);

    // A reload swallows any step landing in the same cycle.
    if (reload) begin
      mode_d     = pat_e'(m2_q);
      led_d      = init_pat(pat_e'(m2_q));
      dir_left_d = 1'b1;
      cnt_d      = CW'(1);
    end else if (step && !p2_q) begin
      tick_d = 1'b1;
      case (mode_q)
        CHASE: led_d = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
        BOUNCE: begin
          if (dir_left_q) begin
            if (led_q[N_LEDS-1]) begin
              led_d      = led_q >> 1;
              dir_left_d = 1'b0;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              led_d      = led_q << 1;
              dir_left_d = 1'b1;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        FILL: begin
          cnt_d = (cnt_q == CW'(N_LEDS)) ? '0 : cnt_q + CW'(1);
          led_d = fill_val(cnt_d);
        end
        BLINK: led_d = ~led_q;
        default: led_d = led_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      m1_q       <= 2'b00;
      m2_q       <= 2'b00;
      p1_q       <= 1'b0;
      p2_q       <= 1'b0;
      mode_q     <= CHASE;
      led_q      <= N_LEDS'(1);
      dir_left_q <= 1'b1;
      cnt_q      <= CW'(1);
      tick_q     <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      m1_q       <= m1_d;
      m2_q       <= m2_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      mode_q     <= mode_d;
      led_q      <= led_d;
      dir_left_q <= dir_left_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
    end
  end

  assign led_out   = led_q;
  assign step_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq (N_LEDS=8): expected LED values are queued as steps are driven
// and popped by a monitor whenever step_tick fires.
module tb_led_pattern_seq;

  logic       clk_in;
  logic       rst;
  logic       step_drv;
  logic       pt_en;
  logic       step_clk;
  logic [1:0] mode;
  logic       pause;
  logic [7:0] led_out;
  logic       step_tick;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  logic [7:0] m_led;
  logic       m_dir;
  int         m_cnt;
  logic [1:0] m_mode;

  assign step_clk = pt_en ? clk_in : step_drv;

  led_pattern_seq #(.N_LEDS(8)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .step_clk  (step_clk),
    .mode      (mode),
    .pause     (pause),
    .led_out   (led_out),
    .step_tick (step_tick)
  );

  initial clk_in = 1'b0;
  always #10 clk_in = ~clk_in;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (!rst && step_tick === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_tick", 32'(step_tick), 32'd0);
      else chk("led_on_tick", 32'(led_out), 32'(sb.pop_front()));
    end
  end

  task automatic model_reset();
    m_mode = 2'b00; m_led = 8'h01; m_dir = 1'b1; m_cnt = 1;
  endtask

  task automatic model_reload(input logic [1:0] m);
    m_mode = m; m_dir = 1'b1; m_cnt = 1;
    m_led = (m == 2'b11) ? 8'h55 : 8'h01;
  endtask

  task automatic model_step();
    case (m_mode)
      2'b00: m_led = {m_led[6:0], m_led[7]};
      2'b01: begin
        if (m_dir) m_led = m_led << 1;
        else m_led = m_led >> 1;
        if (m_led[7]) m_dir = 1'b0;
        if (m_led[0]) m_dir = 1'b1;
      end
      2'b10: begin
        m_cnt = (m_cnt == 8) ? 0 : m_cnt + 1;
        m_led = 8'h00;
        for (int i = 0; i < 8; i++) if (i < m_cnt) m_led[i] = 1'b1;
      end
      default: m_led = ~m_led;
    endcase
  endtask

  task automatic do_step(input bit adv);
    if (adv) begin
      model_step();
      sb.push_back(m_led);
    end
    @(negedge clk_in); step_drv = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 chk("tick_early", 32'(step_tick), 32'd0);
    @(posedge clk_in);
    #1 chk("tick_on_time", 32'(step_tick), 32'(adv));
    if (!adv) chk("led_hold_paused", 32'(led_out), 32'(m_led));
    @(posedge clk_in);
    #1 chk("tick_one_cycle", 32'(step_tick), 32'd0);
    @(negedge clk_in); step_drv = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk_in); mode = m;
    model_reload(m);
    repeat (3) @(posedge clk_in);
    #1 chk("reload_led", 32'(led_out), 32'(m_led));
    chk("reload_no_tick", 32'(step_tick), 32'd0);
    repeat (2) @(negedge clk_in);
  endtask

  initial begin
    rst = 1'b1; step_drv = 1'b0; pt_en = 1'b0; mode = 2'b00; pause = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_in);
    chk("reset_led", 32'(led_out), 32'h01);
    chk("reset_tick", 32'(step_tick), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk_in);
    chk("post_reset_led", 32'(led_out), 32'h01);

    // CHASE
    for (int i = 0; i < 10; i++) do_step(1'b1);

    // BOUNCE through both turn-arounds
    set_mode(2'b01);
    for (int i = 0; i < 16; i++) do_step(1'b1);

    // FILL including wrap to zero
    set_mode(2'b10);
    for (int i = 0; i < 10; i++) do_step(1'b1);

    // CHASE to 0x08, then mode change coinciding with a step
    set_mode(2'b00);
    for (int i = 0; i < 3; i++) do_step(1'b1);
    chk("chase_at_08", 32'(led_out), 32'h08);
    @(negedge clk_in); mode = 2'b11; step_drv = 1'b1;
    model_reload(2'b11);
    repeat (3) @(posedge clk_in);
    #1 chk("coincide_led", 32'(led_out), 32'h55);
    chk("coincide_tick", 32'(step_tick), 32'd0);
    @(negedge clk_in); step_drv = 1'b0;
    repeat (3) @(negedge clk_in);
    do_step(1'b1);
    chk("blink_aa", 32'(led_out), 32'hAA);

    // Pause drops steps
    @(negedge clk_in); pause = 1'b1;
    repeat (3) @(negedge clk_in);
    for (int i = 0; i < 3; i++) do_step(1'b0);
    @(negedge clk_in); pause = 1'b0;
    repeat (3) @(negedge clk_in);
    do_step(1'b1);
    chk("unpause_one_step", 32'(led_out), 32'h55);

    // Async reset mid-BOUNCE at 0x20 heading right
    set_mode(2'b01);
    for (int i = 0; i < 9; i++) do_step(1'b1);
    chk("bounce_at_20", 32'(led_out), 32'h20);
    @(negedge clk_in);
    #2 rst = 1'b1;
    #1 chk("async_reset_led", 32'(led_out), 32'h01);
    chk("async_reset_tick", 32'(step_tick), 32'd0);
    mode = 2'b00;
    model_reset();
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    repeat (4) @(negedge clk_in);
    chk("after_reset_led", 32'(led_out), 32'h01);

    // Park step_clk high, then pass clk_in straight through
    model_step();
    sb.push_back(m_led);
    @(negedge clk_in); step_drv = 1'b1;
    repeat (6) @(negedge clk_in);
    chk("pt_pre_led", 32'(led_out), 32'h02);
    pt_en = 1'b1;
    repeat (1000) @(negedge clk_in);
    chk("pt_hold_led", 32'(led_out), 32'(m_led));

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
